// File: rtl/serial_word_rx_pkg.sv
// Purpose : shared types and line levels for the serial word receiver.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: rx_state_t FSM encoding, idle/start line levels.
package serial_word_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic RX_IDLE_LVL  = 1'b1;
    localparam logic RX_START_LVL = 1'b0;

endpackage

// File: rtl/rx_hold_reg.sv
// Purpose : one-word valid/ready holding register with sticky overrun flag.
// Latency : load_vld on edge N -> out_valid/out_data visible after edge N.
// Backpressure: full register refuses a load unless it drains in the same cycle; refused loads set overrun.
// Ports   : clk, rst (sync, active-high); load_vld/load_dat from the frame FSM;
//           out_data/out_valid/out_ready consumer port; clr_ovr clears overrun; overrun sticky flag.
module rx_hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_vld,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             out_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             drain;
    logic             accept;

    always_comb begin
        drain   = valid_q && out_ready;
        // A word draining this cycle frees the slot for a simultaneous load.
        accept  = load_vld && (!valid_q || out_ready);
        data_d  = accept ? load_dat : data_q;
        valid_d = accept ? 1'b1 : (drain ? 1'b0 : valid_q);
        // Set has priority over clear.
        ovr_d   = (load_vld && !accept) ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: rtl/serial_word_rx.sv
// Purpose : start/data/[parity]/stop serial frame receiver, LSB-first, WIDTH data bits.
// Latency : word/error flags visible one cycle after the stop-bit bit_valid cycle.
// Backpressure: one-word holding register; good frames arriving while it is full are dropped and set overrun.
// Ports   : clk, rst (sync, active-high); bit_valid/sin serial input; out_data/out_valid/out_ready
//           word output; frame_err/par_err one-cycle pulses; overrun sticky, cleared by clr_ovr; busy.
// Build   : define SERIAL_WORD_RX_PARITY_EN to expect an even-parity bit after the data bits.
module serial_word_rx
    import serial_word_rx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             sin,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             par_err,
    output logic             overrun,
    input  logic             clr_ovr,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    rx_state_t        state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             frame_err_q, frame_err_d;
    logic             par_err_q, par_err_d;
    logic             perr_q, perr_d;   // parity mismatch seen in PARITY, reported at STOP
    logic             good_vld;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        perr_d      = perr_q;
        frame_err_d = 1'b0;
        par_err_d   = 1'b0;
        good_vld    = 1'b0;
        if (bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (sin == RX_START_LVL) begin
                        state_d = DATA;
                        acc_d   = '0;
                        cnt_d   = '0;
                        perr_d  = 1'b0;
                    end
                end
                DATA: begin
                    acc_d = {sin, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
`ifdef SERIAL_WORD_RX_PARITY_EN
                PARITY: begin
                    // Even parity: data bits XOR parity bit must be 0.
                    perr_d  = ^{acc_q, sin};
                    state_d = STOP;
                end
`endif
                STOP: begin
                    state_d     = IDLE;
                    frame_err_d = (sin != RX_IDLE_LVL);
                    par_err_d   = perr_q;
                    good_vld    = (sin == RX_IDLE_LVL) && !perr_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            perr_q      <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            perr_q      <= perr_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
        end
    end

    rx_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load_vld  (good_vld),
        .load_dat  (acc_q),
        .out_ready (out_ready),
        .clr_ovr   (clr_ovr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    assign frame_err = frame_err_q;
    assign par_err   = par_err_q;
    assign busy      = (state_q != IDLE);

endmodule
